// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared pipeline latch command and hazard FSM state types
//
// Purpose: types shared by the hazard controller and the four pipeline latches.
//   pipe_state_t : latch command (ENABLE=load, STALL=hold, NOP=load bubble)
//   ctl_state_t  : hazard controller FSM state (RUN, DWAIT, HALT)
// Ports: none (package).
package cpu_types_pkg;

    typedef enum logic [1:0] {
        PIPE_ENABLE = 2'b00,
        PIPE_STALL  = 2'b01,
        PIPE_NOP    = 2'b10
    } pipe_state_t;

    typedef logic [1:0] ctl_state_t;

    localparam ctl_state_t CTL_RUN   = 2'd0;
    localparam ctl_state_t CTL_DWAIT = 2'd1;
    localparam ctl_state_t CTL_HALT  = 2'd2;

endpackage

// File: rtl/pipeline_load_use_detect.sv
// rtl/pipeline_load_use_detect.sv - combinational load-use hazard compare
//
// Purpose: flags a load in EX whose destination is read by the instruction in ID.
// Ports:
//   i_dren_ex    in  1     load in EX
//   i_regwsel_ex in  REGW  destination register of the EX instruction
//   i_rs_id      in  REGW  rs of the ID instruction
//   i_rt_id      in  REGW  rt of the ID instruction
//   o_load_use   out 1     one bubble required
module pipeline_load_use_detect #(
    parameter int REGW = 5
) (
    input  logic            i_dren_ex,
    input  logic [REGW-1:0] i_regwsel_ex,
    input  logic [REGW-1:0] i_rs_id,
    input  logic [REGW-1:0] i_rt_id,
    output logic            o_load_use
);

    logic w_dest_nonzero;
    logic w_src_match;

    // $0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign w_dest_nonzero = (i_regwsel_ex != '0);
    assign w_src_match    = (i_regwsel_ex == i_rs_id) || (i_regwsel_ex == i_rt_id);
    assign o_load_use     = i_dren_ex && w_dest_nonzero && w_src_match;

endmodule

// File: rtl/pipeline_hazard_control.sv
// rtl/pipeline_hazard_control.sv - 5-stage pipeline latch commands and PC enable
//
// Purpose: sole source of the IF/ID, ID/EX, EX/MEM, MEM/WB latch commands and the PC
// write enable. Resolves halt, dcache waits, taken redirects (resolved in MEM),
// load-use hazards and icache misses, in that priority order.
// Optional feature macro: PIPE_PERF_EN (stall/flush perf counters; tied to 0 otherwise).
// Ports:
//   CLK, nRST          clock, asynchronous active-low reset
//   ihit, dhit         icache / dcache completion
//   dREN_mem, dWEN_mem load / store in MEM
//   PCSrc_mem          taken branch/jump in MEM
//   halt_mem           halt instruction in MEM
//   dREN_ex            load in EX
//   regWSEL_ex         EX destination register
//   rs_id, rt_id       ID source registers
//   pc_en              PC write enable
//   fd/de/em/mw_state  latch commands (pipe_state_t encoding)
//   halt               sticky halted flag
//   stall_cnt          cycles with pc_en=0 outside HALT
//   flush_cnt          taken redirects
module pipeline_hazard_control
    import cpu_types_pkg::*;
#(
    parameter int REGW = 5,
    parameter int CNTW = 32
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            ihit,
    input  logic            dhit,
    input  logic            dREN_mem,
    input  logic            dWEN_mem,
    input  logic            PCSrc_mem,
    input  logic            halt_mem,
    input  logic            dREN_ex,
    input  logic [REGW-1:0] regWSEL_ex,
    input  logic [REGW-1:0] rs_id,
    input  logic [REGW-1:0] rt_id,
    output logic            pc_en,
    output logic [1:0]      fd_state,
    output logic [1:0]      de_state,
    output logic [1:0]      em_state,
    output logic [1:0]      mw_state,
    output logic            halt,
    output logic [CNTW-1:0] stall_cnt,
    output logic [CNTW-1:0] flush_cnt
);

    ctl_state_t r_state;
    ctl_state_t w_next_state;
    logic       r_halt;
    logic       w_load_use;
    logic       w_flush;

    pipeline_load_use_detect #(.REGW(REGW)) u_load_use (
        .i_dren_ex    (dREN_ex),
        .i_regwsel_ex (regWSEL_ex),
        .i_rs_id      (rs_id),
        .i_rt_id      (rt_id),
        .o_load_use   (w_load_use)
    );

    // Priority mux. DWAIT only matters through the MEM access still being
    // outstanding: once dhit arrives (or the access drops) rows 4-7 apply and
    // the FSM falls back to RUN.
    always_comb begin
        pc_en        = 1'b1;
        fd_state     = PIPE_ENABLE;
        de_state     = PIPE_ENABLE;
        em_state     = PIPE_ENABLE;
        mw_state     = PIPE_ENABLE;
        w_flush      = 1'b0;
        w_next_state = CTL_RUN;
        if (r_state == CTL_HALT) begin
            pc_en        = 1'b0;
            fd_state     = PIPE_STALL;
            de_state     = PIPE_STALL;
            em_state     = PIPE_STALL;
            mw_state     = PIPE_STALL;
            w_next_state = CTL_HALT;
        end else if (halt_mem) begin
            // Let the halt retire through MEM/WB, squash everything younger.
            pc_en        = 1'b0;
            fd_state     = PIPE_NOP;
            de_state     = PIPE_NOP;
            em_state     = PIPE_NOP;
            w_next_state = CTL_HALT;
        end else if ((dREN_mem || dWEN_mem) && !dhit) begin
            pc_en        = 1'b0;
            fd_state     = PIPE_STALL;
            de_state     = PIPE_STALL;
            em_state     = PIPE_STALL;
            mw_state     = PIPE_STALL;
            w_next_state = CTL_DWAIT;
        end else if (PCSrc_mem) begin
            // Redirect: load target PC and squash the three younger instructions.
            fd_state = PIPE_NOP;
            de_state = PIPE_NOP;
            em_state = PIPE_NOP;
            w_flush  = 1'b1;
        end else if (w_load_use) begin
            // Hold IF/ID, inject exactly one bubble into ID/EX.
            pc_en    = 1'b0;
            fd_state = PIPE_STALL;
            de_state = PIPE_NOP;
        end else if (!ihit) begin
            pc_en    = 1'b0;
            fd_state = PIPE_NOP;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= CTL_RUN;
            r_halt  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_next_state == CTL_HALT) begin
                r_halt <= 1'b1;
            end
        end
    end

    assign halt = r_halt;

`ifdef PIPE_PERF_EN
    localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

    logic [CNTW-1:0] r_stall_cnt;
    logic [CNTW-1:0] r_flush_cnt;

    // Counters freeze once halted; they wrap naturally at 2^CNTW.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (r_state != CTL_HALT) begin
            if (!pc_en) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
            if (w_flush) begin
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
